// File: rtl/serial_tx_ctrl_if.sv
// Handshake and data bundle between a parallel word source and serial_tx_ctrl.
// The source holds the master modport and the controller holds the slave modport.
interface serial_tx_ctrl_if #(
  parameter int NBITS_REG = 4
);
  logic [NBITS_REG-1:0] din;
  logic                 start;
  logic                 abort;
  logic                 sout;
  logic                 busy;
  logic                 done;
  logic [NBITS_REG-1:0] shreg_q;

  modport master (
    output din, start, abort,
    input  sout, busy, done, shreg_q
  );

  modport slave (
    input  din, start, abort,
    output sout, busy, done, shreg_q
  );
endinterface

// File: rtl/serial_tx_ctrl.sv
// Frames a parallel word as start bit, LSB-first data and stop bit on one wire.
// Each bit is held for DIV clocks. A start/busy/done handshake wraps the shift register.
module serial_tx_ctrl #(
  parameter int NBITS_REG = 4,
  parameter int DIV       = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  serial_tx_ctrl_if.slave  bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (NBITS_REG > 1) ? $clog2(NBITS_REG) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [DIV_W-1:0]     div_cnt, div_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [NBITS_REG-1:0] shreg, shreg_n;
  logic                 done_q, done_n;
  logic [NBITS_REG:0]   fill_shift;
  logic                 div_last;
  logic                 bit_last;

  assign div_last   = (div_cnt == DIV_W'(DIV - 1));
  assign bit_last   = (bit_cnt == BIT_W'(NBITS_REG - 1));
  assign fill_shift = {1'b1, shreg};

  // NOTE: every variable gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          shreg_n = bus.din;
          div_n   = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (div_last) begin
          div_n   = '0;
          state_n = DATA;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (div_last) begin
          shreg_n = fill_shift[NBITS_REG:1];
          div_n   = '0;
          if (bit_last) state_n = STOP;
          else          bit_n   = bit_cnt + BIT_W'(1);
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      STOP: begin
        if (div_last) begin
          div_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides every transition but leaves the shift register for display.
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      div_n   = '0;
      bit_n   = '0;
      shreg_n = shreg;
      done_n  = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      done_q  <= done_n;
    end
  end

  // Outputs decode registered state only, so inputs never reach them combinationally.
  always_comb begin
    bus.sout = 1'b1;
    unique case (state)
      START:   bus.sout = 1'b0;
      DATA:    bus.sout = shreg[0];
      default: bus.sout = 1'b1;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.shreg_q = shreg;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl at DIV=1, 2 and 4 with hand-computed serial patterns.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_tx_ctrl;

  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_2 = ~clk_2;

  serial_tx_ctrl_if #(.NBITS_REG(4)) b1 ();
  serial_tx_ctrl_if #(.NBITS_REG(4)) b2 ();
  serial_tx_ctrl_if #(.NBITS_REG(4)) b4 ();

  serial_tx_ctrl #(.NBITS_REG(4), .DIV(1)) u1 (.clk_2(clk_2), .reset(reset), .bus(b1));
  serial_tx_ctrl #(.NBITS_REG(4), .DIV(2)) u2 (.clk_2(clk_2), .reset(reset), .bus(b2));
  serial_tx_ctrl #(.NBITS_REG(4), .DIV(4)) u4 (.clk_2(clk_2), .reset(reset), .bus(b4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected sout per cycle after the accepting edge (index 0 = cycle k+1).
  int exp_1011[14] = '{0,0,1,1,1,1,0,0,1,1,1,1,1,1};
  int exp_b2b_s[15] = '{0,0,0,0,0,1,1,0,1,0,1,0,1,1,1};
  int exp_b2b_d[15] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,1,0};
  int exp_a[16]    = '{0,0,0,0,1,1,0,0,1,1,1,1,1,1,1,1};

  logic done_seen;
  logic busy_seen;

  initial begin
    b1.din = 4'hF; b1.start = 1'b1; b1.abort = 1'b0;
    b2.din = 4'hF; b2.start = 1'b1; b2.abort = 1'b0;
    b4.din = 4'hF; b4.start = 1'b1; b4.abort = 1'b0;

    // Reset held with start asserted: nothing may start.
    repeat (3) @(negedge clk_2);
    check("rst_sout1",  b1.sout, 1);    check("rst_busy1", b1.busy, 0);
    check("rst_done1",  b1.done, 0);    check("rst_sh1",   b1.shreg_q, 0);
    check("rst_sout2",  b2.sout, 1);    check("rst_busy2", b2.busy, 0);
    check("rst_done2",  b2.done, 0);    check("rst_sh2",   b2.shreg_q, 0);
    check("rst_sout4",  b4.sout, 1);    check("rst_busy4", b4.busy, 0);
    check("rst_done4",  b4.done, 0);    check("rst_sh4",   b4.shreg_q, 0);
    b1.start = 1'b0; b2.start = 1'b0; b4.start = 1'b0;
    reset = 1'b1;
    @(negedge clk_2);
    check("post_rst_busy", b2.busy, 0);

    // Single frame, DIV=2, din=1011.
    b2.din = 4'b1011; b2.start = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk_2);
      b2.start = 1'b0;
      check($sformatf("f1_sout_c%0d", j), b2.sout, exp_1011[j-1]);
      check($sformatf("f1_busy_c%0d", j), b2.busy, (j <= 12) ? 1 : 0);
      check($sformatf("f1_done_c%0d", j), b2.done, (j == 13) ? 1 : 0);
    end
    check("f1_shreg", b2.shreg_q, 4'hF);

    // Back-to-back, DIV=1: start held, 4'h0 then 4'h5.
    b1.din = 4'h0; b1.start = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk_2);
      check($sformatf("b2b_sout_c%0d", j), b1.sout, exp_b2b_s[j-1]);
      check($sformatf("b2b_done_c%0d", j), b1.done, exp_b2b_d[j-1]);
      check($sformatf("b2b_busy_c%0d", j), b1.busy,
            ((j <= 6) || (j >= 8 && j <= 13)) ? 1 : 0);
      if (j == 1) b1.din = 4'h5;
      if (j == 8) b1.start = 1'b0;
    end
    check("b2b_shreg", b1.shreg_q, 4'hF);

    // Start during DATA of a 4'hA frame is ignored.
    b2.din = 4'hA; b2.start = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk_2);
      check($sformatf("ign_sout_c%0d", j), b2.sout, exp_a[j-1]);
      check($sformatf("ign_busy_c%0d", j), b2.busy, (j <= 12) ? 1 : 0);
      check($sformatf("ign_done_c%0d", j), b2.done, (j == 13) ? 1 : 0);
      if (j == 1) b2.start = 1'b0;
      if (j == 6) begin b2.start = 1'b1; b2.din = 4'h3; end
      if (j == 9) b2.start = 1'b0;
    end
    check("ign_shreg", b2.shreg_q, 4'hF);

    // Abort in the second DATA bit, DIV=4, din=0110.
    b4.din = 4'b0110; b4.start = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk_2);
      if (j == 1) begin
        b4.start = 1'b0;
        check("ab_busy_c1", b4.busy, 1);
        check("ab_sout_c1", b4.sout, 0);
      end
      if (j == 5) check("ab_bit0", b4.sout, 0);
      if (j == 9) check("ab_bit1", b4.sout, 1);
      if (j == 10) b4.abort = 1'b1;
      if (j == 11) begin
        check("ab_busy", b4.busy, 0);
        check("ab_sout", b4.sout, 1);
        check("ab_done", b4.done, 0);
        check("ab_shreg", b4.shreg_q, 4'hB);
        b4.abort = 1'b0;
      end
    end
    done_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk_2);
      done_seen |= b4.done;
      busy_seen |= b4.busy;
    end
    check("ab_no_done", done_seen, 0);
    check("ab_stays_idle", busy_seen, 0);

    // Abort and start together in IDLE: start dropped.
    b4.start = 1'b1; b4.abort = 1'b1;
    @(negedge clk_2);
    b4.start = 1'b0; b4.abort = 1'b0;
    check("ab_st_busy", b4.busy, 0);
    check("ab_st_sout", b4.sout, 1);

    // A fresh start after abort, din=1001.
    b4.din = 4'h9; b4.start = 1'b1;
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk_2);
      if (j == 1) begin
        b4.start = 1'b0;
        check("re_busy_c1", b4.busy, 1);
        check("re_sout_c1", b4.sout, 0);
      end
      if (j == 5)  check("re_bit0", b4.sout, 1);
      if (j == 9)  check("re_bit1", b4.sout, 0);
      if (j == 24) check("re_done_early", b4.done, 0);
      if (j == 25) begin
        check("re_done", b4.done, 1);
        check("re_busy_end", b4.busy, 0);
        check("re_shreg", b4.shreg_q, 4'hF);
      end
      if (j == 26) check("re_done_once", b4.done, 0);
    end

    // Asynchronous reset between edges during STOP.
    b4.din = 4'h0; b4.start = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk_2);
      if (j == 1) b4.start = 1'b0;
    end
    check("ar_stop_busy", b4.busy, 1);
    check("ar_stop_sout", b4.sout, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_busy", b4.busy, 0);
    check("ar_sout", b4.sout, 1);
    check("ar_shreg", b4.shreg_q, 0);
    check("ar_done", b4.done, 0);
    @(negedge clk_2);
    reset = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (30) begin
      @(negedge clk_2);
      done_seen |= b4.done;
      busy_seen |= b4.busy;
    end
    check("ar_no_done", done_seen, 0);
    check("ar_stays_idle", busy_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
